bcd_time_counter: RTL and testbench
===================================

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 5_000_000: rising edges of tick_lvl per second, legal range 2..2^24-1.
REQ-002 SHALL have port clk_in_50M  input  1  system clock, 50 MHz, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port tick_lvl  input  1  divided square wave from the upstream clock divider, synchronous to clk_in_50M.
REQ-005 SHALL have port run_en  input  1  1 = timekeeping advances, 0 = time held.
REQ-006 SHALL have port set_valid  input  1  time-load request.
REQ-007 SHALL have port set_hh, set_mm, set_ss  input  8 each  packed BCD load value {tens,ones}.
REQ-008 SHALL have port set_ready  output  1  load can be accepted this cycle.
REQ-009 SHALL have port set_err  output  1  one-cycle pulse: accepted load value was illegal.
REQ-010 SHALL have port hh, mm, ss  output  8 each  current time, packed BCD.
REQ-011 SHALL have port sec_pulse  output  1  one-cycle pulse on every second increment.
REQ-012 SHALL have port day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.

Function
REQ-013 SHALL register tick_lvl into tick_d every cycle; edge = tick_lvl & ~tick_d.
REQ-014 SHALL hold a prescaler (ceil(log2 TICKS_PER_SEC) bits) that increments on edge when state is RUN; at TICKS_PER_SEC-1 with edge it returns to 0 and generates a second increment.
REQ-015 SHALL update hh/mm/ss and assert sec_pulse in the cycle after the final counted edge (latency: 1 cycle from edge to new time).
REQ-016 SHALL increment ss ones 0..9 with carry into tens 0..5; 59 -> 00 carries into mm, same rule; mm 59 -> 00 carries into hh; hh 23 -> 00 asserts day_pulse together with sec_pulse.
REQ-017 SHALL use the states RUN, HOLD and LOAD.
REQ-018 SHALL transition RUN -> HOLD when run_en=0, HOLD -> RUN when run_en=1, RUN/HOLD -> LOAD on transfer, and LOAD -> RUN or HOLD per run_en after exactly one cycle.
REQ-019 SHALL drive set_ready=1 in RUN and HOLD and 0 in LOAD; a transfer is set_valid & set_ready in the same cycle.
REQ-020 SHALL, on transfer with a legal value (all digits <= 9, ss and mm <= 0x59, hh <= 0x23), load hh/mm/ss the next cycle and clear the prescaler.
REQ-021 SHALL, on transfer with an illegal value, leave the time and prescaler unchanged, pulse set_err next cycle, and still enter LOAD.
REQ-022 SHALL give a transfer priority over a second increment in the same cycle: the increment is discarded and sec_pulse/day_pulse stay 0.
REQ-023 SHALL ignore edges in HOLD and LOAD (prescaler frozen, tick_d still tracks tick_lvl).
REQ-024 SHALL keep set_valid while set_ready=0 pending without effect; it is accepted once ready returns.

Reset
REQ-025 SHALL, when rst_n=0 at a clk_in_50M edge, set hh/mm/ss=0x00, prescaler=0, tick_d=0, sec_pulse=day_pulse=set_err=0, state=HOLD.
REQ-026 SHALL hold set_ready=0 while rst_n=0 and drive it to 1 in the first cycle after release.
REQ-027 SHALL let reset during LOAD or on a second boundary override everything: no load, no pulses.

Structure
REQ-028 SHALL take the state enum, BCD limits (0x59, 0x23) and the TICKS_PER_SEC default from shared package digital_clock_pkg.
REQ-029 SHALL instantiate sub-module bcd_digit_counter (parameter MAX, inputs inc and load, outputs digit and carry) once per BCD digit: six instances.

Verification (TICKS_PER_SEC=4)
REQ-030 SHALL verify: reset, run_en=1, 4 tick_lvl rising edges -> ss=0x01 and one sec_pulse, 1 cycle after the 4th edge.
REQ-031 SHALL verify: load 23:59:59 legal, then 4 edges -> 00:00:00, with sec_pulse and day_pulse in the same cycle.
REQ-032 SHALL verify: load set_mm=0x60 -> set_err pulse, time unchanged, set_ready low for 1 cycle.
REQ-033 SHALL verify: transfer of 12:00:00 in the same cycle as the 4th edge -> time 12:00:00, no sec_pulse, prescaler 0.
REQ-034 SHALL verify: run_en=0 with 10 edges -> time and prescaler unchanged; run_en=1 then 4 edges -> ss increments by exactly 1.
REQ-035 SHALL verify: rst_n=0 for 1 cycle at 00:00:09 with 3 edges counted -> 00:00:00, prescaler 0, state HOLD.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared definitions for the digital clock blocks.
//
// Contents:
//   state_t                - timekeeping control states (run, hold, load)
//   BCD_MAX_MIN_SEC        - highest legal packed-BCD minute/second value (59)
//   BCD_MAX_HOUR           - highest legal packed-BCD hour value (23)
//   DEFAULT_TICKS_PER_SEC  - default number of tick_lvl rising edges per second
//   bcd_legal()            - checks a packed-BCD byte against an upper limit
package digital_clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [7:0] BCD_MAX_MIN_SEC       = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR          = 8'h23;
    localparam int         DEFAULT_TICKS_PER_SEC = 5_000_000;

    // Both digits must be decimal. Once they are, the packed byte orders the
    // same way as the decimal value, so a plain compare checks the limit.
    function automatic logic bcd_legal(input logic [7:0] value, input logic [7:0] limit);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decimal digit of the time-of-day counter.
//
// Parameters:
//   MAX        - value after which the digit wraps to 0 and carries
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset, clears the digit
//   inc        - advance the digit by one this cycle
//   limit      - forces an early wrap (used for the hours ones digit at 23)
//   load       - overwrite the digit with load_value (wins over inc)
//   load_value - value to load
//   digit      - current digit value
//   carry      - combinational: this increment wraps the digit
module bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       limit,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       carry
);

    // The carry is combinational so that the whole chain of digits ripples
    // within the same cycle and every digit updates on the same edge.
    assign carry = inc & ((digit == MAX) | limit);

    // Digit register: reset, then load, then increment with wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_value;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day counter (hh:mm:ss in packed BCD) advanced by a divided tick.
//
// Parameters:
//   TICKS_PER_SEC - rising edges of tick_lvl per second (2 .. 2^24-1)
// Ports:
//   clk_in_50M        - system clock
//   rst_n             - synchronous active-low reset
//   tick_lvl          - divided square wave, synchronous to clk_in_50M
//   run_en            - 1 = time advances, 0 = time held
//   set_valid         - time-load request
//   set_hh/mm/ss      - packed-BCD load value
//   set_ready         - a load can be accepted this cycle
//   set_err           - one-cycle pulse: accepted load value was illegal
//   hh/mm/ss          - current time, packed BCD
//   sec_pulse         - one-cycle pulse on every second increment
//   day_pulse         - one-cycle pulse on the 23:59:59 -> 00:00:00 wrap
module bcd_time_counter
    import digital_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
    input  logic       clk_in_50M,
    input  logic       rst_n,
    input  logic       tick_lvl,
    input  logic       run_en,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_ready,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       day_pulse
);

    localparam int                PRE_W    = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    state_t           state;
    state_t           state_next;
    logic             tick_d;
    logic             tick_edge;
    logic [PRE_W-1:0] prescaler;
    logic             transfer;
    logic             set_legal;
    logic             do_load;
    logic             sec_inc;

    logic [3:0] ss_ones, ss_tens, mm_ones, mm_tens, hh_ones, hh_tens;
    logic       ss_ones_carry, ss_tens_carry, mm_ones_carry, mm_tens_carry;
    logic       hh_ones_carry, hh_tens_carry;
    logic       hour_limit;

    assign tick_edge = tick_lvl & ~tick_d;
    assign transfer  = set_valid & set_ready;
    assign set_legal = bcd_legal(set_hh, BCD_MAX_HOUR)
                     & bcd_legal(set_mm, BCD_MAX_MIN_SEC)
                     & bcd_legal(set_ss, BCD_MAX_MIN_SEC);
    assign do_load   = transfer & set_legal;

    // A transfer in the same cycle as the final counted edge swallows the
    // second: no digit moves and no pulse is produced.
    assign sec_inc   = (state == ST_RUN) & tick_edge & (prescaler == PRE_LAST) & ~transfer;

    // State register; reset parks the counter in HOLD.
    always_ff @(posedge clk_in_50M) begin
        if (!rst_n) begin
            state <= ST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: any accepted load passes through LOAD for exactly
    // one cycle, otherwise run_en alone selects RUN or HOLD.
    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = ST_LOAD;
        end else begin
            case (state)
                ST_RUN, ST_HOLD, ST_LOAD: state_next = run_en ? ST_RUN : ST_HOLD;
                default:                  state_next = ST_HOLD;
            endcase
        end
    end

    // Output logic: ready is forced low while reset is asserted so that no
    // load can be seen as accepted during reset.
    always_comb begin
        set_ready = 1'b0;
        if (rst_n && (state != ST_LOAD)) begin
            set_ready = 1'b1;
        end
    end

    // Edge detector history; it keeps tracking tick_lvl in every state so a
    // level that was already high when RUN is entered is not seen as an edge.
    always_ff @(posedge clk_in_50M) begin
        if (!rst_n) begin
            tick_d <= 1'b0;
        end else begin
            tick_d <= tick_lvl;
        end
    end

    // Prescaler: counts edges only in RUN, frozen during any transfer (an
    // illegal load leaves it untouched, a legal one restarts the second).
    always_ff @(posedge clk_in_50M) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (do_load) begin
            prescaler <= '0;
        end else if ((state == ST_RUN) && tick_edge && !transfer) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
        end
    end

    // Registered status pulses, aligned with the digit update they describe.
    always_ff @(posedge clk_in_50M) begin
        if (!rst_n) begin
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_pulse <= sec_inc;
            day_pulse <= hh_tens_carry;
            set_err   <= transfer & ~set_legal;
        end
    end

    // The hours ones digit wraps at 3 rather than 9 when the tens digit is 2.
    assign hour_limit = (hh_tens == BCD_MAX_HOUR[7:4]) && (hh_ones == BCD_MAX_HOUR[3:0]);

    bcd_digit_counter #(.MAX(4'd9)) u_ss_ones (
        .clk(clk_in_50M), .rst_n(rst_n), .inc(sec_inc), .limit(1'b0),
        .load(do_load), .load_value(set_ss[3:0]), .digit(ss_ones), .carry(ss_ones_carry)
    );

    bcd_digit_counter #(.MAX(BCD_MAX_MIN_SEC[7:4])) u_ss_tens (
        .clk(clk_in_50M), .rst_n(rst_n), .inc(ss_ones_carry), .limit(1'b0),
        .load(do_load), .load_value(set_ss[7:4]), .digit(ss_tens), .carry(ss_tens_carry)
    );

    bcd_digit_counter #(.MAX(4'd9)) u_mm_ones (
        .clk(clk_in_50M), .rst_n(rst_n), .inc(ss_tens_carry), .limit(1'b0),
        .load(do_load), .load_value(set_mm[3:0]), .digit(mm_ones), .carry(mm_ones_carry)
    );

    bcd_digit_counter #(.MAX(BCD_MAX_MIN_SEC[7:4])) u_mm_tens (
        .clk(clk_in_50M), .rst_n(rst_n), .inc(mm_ones_carry), .limit(1'b0),
        .load(do_load), .load_value(set_mm[7:4]), .digit(mm_tens), .carry(mm_tens_carry)
    );

    bcd_digit_counter #(.MAX(4'd9)) u_hh_ones (
        .clk(clk_in_50M), .rst_n(rst_n), .inc(mm_tens_carry), .limit(hour_limit),
        .load(do_load), .load_value(set_hh[3:0]), .digit(hh_ones), .carry(hh_ones_carry)
    );

    bcd_digit_counter #(.MAX(BCD_MAX_HOUR[7:4])) u_hh_tens (
        .clk(clk_in_50M), .rst_n(rst_n), .inc(hh_ones_carry), .limit(1'b0),
        .load(do_load), .load_value(set_hh[7:4]), .digit(hh_tens), .carry(hh_tens_carry)
    );

    assign hh = {hh_tens, hh_ones};
    assign mm = {mm_tens, mm_ones};
    assign ss = {ss_tens, ss_ones};

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter with TICKS_PER_SEC = 4.
// Expected output snapshots are queued when the stimulus is driven and
// popped and compared once the DUT has had the cycle to respond.
module tb_bcd_time_counter;
    import digital_clock_pkg::*;

    localparam int TPS = 4;

    logic       clk_in_50M;
    logic       rst_n;
    logic       tick_lvl;
    logic       run_en;
    logic       set_valid;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       set_ready;
    logic       set_err;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_pulse;
    logic       day_pulse;

    typedef struct {
        string      tag;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       sec;
        logic       day;
        logic       err;
        logic       ready;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    bcd_time_counter #(.TICKS_PER_SEC(TPS)) dut (
        .clk_in_50M(clk_in_50M),
        .rst_n(rst_n),
        .tick_lvl(tick_lvl),
        .run_en(run_en),
        .set_valid(set_valid),
        .set_hh(set_hh),
        .set_mm(set_mm),
        .set_ss(set_ss),
        .set_ready(set_ready),
        .set_err(set_err),
        .hh(hh),
        .mm(mm),
        .ss(ss),
        .sec_pulse(sec_pulse),
        .day_pulse(day_pulse)
    );

    // 50 MHz clock
    initial clk_in_50M = 1'b0;
    always #10 clk_in_50M = ~clk_in_50M;

    // Advance n clock edges, leaving the bench 1 ns past the last edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_in_50M);
            #1;
        end
    endtask

    // One tick_lvl rising edge: low for a cycle, then high; the edge is
    // counted at the second clock edge and the bench returns just after it.
    task automatic tick_once();
        tick_lvl = 1'b0;
        cycles(1);
        tick_lvl = 1'b1;
        cycles(1);
    endtask

    // Drive a load request.
    task automatic applyStimulus(input logic valid, input logic [7:0] h, input logic [7:0] m,
                                 input logic [7:0] s);
        set_valid = valid;
        set_hh    = h;
        set_mm    = m;
        set_ss    = s;
    endtask

    task automatic pushExpect(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic sec, input logic day,
                              input logic err, input logic ready);
        exp_t e;
        e.tag   = tag;
        e.hh    = h;
        e.mm    = m;
        e.ss    = s;
        e.sec   = sec;
        e.day   = day;
        e.err   = err;
        e.ready = ready;
        sb_q.push_back(e);
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            checkVal({e.tag, ".hh"},    hh, e.hh);
            checkVal({e.tag, ".mm"},    mm, e.mm);
            checkVal({e.tag, ".ss"},    ss, e.ss);
            checkVal({e.tag, ".sec"},   {7'd0, sec_pulse}, {7'd0, e.sec});
            checkVal({e.tag, ".day"},   {7'd0, day_pulse}, {7'd0, e.day});
            checkVal({e.tag, ".err"},   {7'd0, set_err},   {7'd0, e.err});
            checkVal({e.tag, ".ready"}, {7'd0, set_ready}, {7'd0, e.ready});
        end
    endtask

    task automatic checkInternal(input string tag, input int pre, input state_t st);
        #1;
        checkVal({tag, ".prescaler"}, 8'(dut.prescaler), 8'(pre));
        checkVal({tag, ".state"},     8'(dut.state),     8'(st));
    endtask

    initial begin
        rst_n    = 1'b0;
        run_en   = 1'b1;
        tick_lvl = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        cycles(2);

        // Reset state and ready behaviour around release
        pushExpect("reset", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        checkOutput();
        checkInternal("reset", 0, ST_HOLD);
        rst_n = 1'b1;
        pushExpect("release", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        checkOutput();
        cycles(1);
        checkInternal("to_run", 0, ST_RUN);

        // Four edges make one second, visible one cycle after the fourth
        repeat (3) tick_once();
        pushExpect("three_edges", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        checkOutput();
        checkInternal("three_edges", 3, ST_RUN);
        tick_once();
        pushExpect("first_sec", 8'h00, 8'h00, 8'h01, 1, 0, 0, 1);
        checkOutput();
        checkInternal("first_sec", 0, ST_RUN);
        cycles(1);
        pushExpect("sec_clear", 8'h00, 8'h00, 8'h01, 0, 0, 0, 1);
        checkOutput();

        // Legal load of 23:59:59 then the day wrap
        applyStimulus(1'b1, 8'h23, 8'h59, 8'h59);
        cycles(1);
        set_valid = 1'b0;
        pushExpect("load_2359", 8'h23, 8'h59, 8'h59, 0, 0, 0, 0);
        checkOutput();
        checkInternal("load_2359", 0, ST_LOAD);
        cycles(1);
        checkInternal("after_load", 0, ST_RUN);
        repeat (3) tick_once();
        pushExpect("pre_wrap", 8'h23, 8'h59, 8'h59, 0, 0, 0, 1);
        checkOutput();
        tick_once();
        pushExpect("day_wrap", 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
        checkOutput();

        // Illegal minute value: error pulse, time kept, one cycle of LOAD
        applyStimulus(1'b1, 8'h10, 8'h60, 8'h00);
        cycles(1);
        set_valid = 1'b0;
        pushExpect("bad_load", 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
        checkOutput();
        checkInternal("bad_load", 0, ST_LOAD);
        cycles(1);
        pushExpect("after_bad", 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        checkOutput();

        // Load coinciding with the fourth edge wins over the increment
        repeat (3) tick_once();
        checkInternal("pre_collide", 3, ST_RUN);
        tick_lvl = 1'b0;
        cycles(1);
        tick_lvl = 1'b1;
        applyStimulus(1'b1, 8'h12, 8'h00, 8'h00);
        cycles(1);
        set_valid = 1'b0;
        pushExpect("load_beats_sec", 8'h12, 8'h00, 8'h00, 0, 0, 0, 0);
        checkOutput();
        checkInternal("load_beats_sec", 0, ST_LOAD);

        // Held time ignores edges; resuming advances exactly one second
        run_en = 1'b0;
        cycles(1);
        checkInternal("enter_hold", 0, ST_HOLD);
        repeat (10) tick_once();
        pushExpect("hold", 8'h12, 8'h00, 8'h00, 0, 0, 0, 1);
        checkOutput();
        checkInternal("hold", 0, ST_HOLD);
        run_en = 1'b1;
        cycles(1);
        repeat (3) tick_once();
        pushExpect("resume_pre", 8'h12, 8'h00, 8'h00, 0, 0, 0, 1);
        checkOutput();
        tick_once();
        pushExpect("resume_sec", 8'h12, 8'h00, 8'h01, 1, 0, 0, 1);
        checkOutput();

        // A request held through LOAD is taken again once ready returns
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h09);
        cycles(1);
        pushExpect("load_09", 8'h00, 8'h00, 8'h09, 0, 0, 0, 0);
        checkOutput();
        cycles(1);
        pushExpect("pending_ready", 8'h00, 8'h00, 8'h09, 0, 0, 0, 1);
        checkOutput();
        cycles(1);
        checkInternal("pending_taken", 0, ST_LOAD);
        set_valid = 1'b0;
        cycles(1);

        // Reset mid-second clears time and prescaler
        repeat (3) tick_once();
        checkInternal("pre_reset", 3, ST_RUN);
        rst_n = 1'b0;
        cycles(1);
        pushExpect("reset_mid", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        checkOutput();
        checkInternal("reset_mid", 0, ST_HOLD);
        rst_n = 1'b1;
        cycles(1);

        // Reset on a second boundary suppresses the increment and pulses
        repeat (3) tick_once();
        tick_lvl = 1'b0;
        cycles(1);
        tick_lvl = 1'b1;
        rst_n    = 1'b0;
        cycles(1);
        pushExpect("reset_on_sec", 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        checkOutput();
        checkInternal("reset_on_sec", 0, ST_HOLD);
        rst_n = 1'b1;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
